// File: rtl/keyb_scanner_pkg.sv
// Shared types and constants for the 4x4 calculator keypad scanner.
// Key codes are row*N_COLS + col; the map below names the calculator legends.
package keyb_scanner_pkg;

  localparam int N_ROWS     = 4;
  localparam int N_COLS     = 4;
  localparam int KEY_CODE_W = 4;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Keypad legend map consumed by the downstream decoder
  localparam logic [KEY_CODE_W-1:0] KEY_7   = 4'd0;
  localparam logic [KEY_CODE_W-1:0] KEY_8   = 4'd1;
  localparam logic [KEY_CODE_W-1:0] KEY_9   = 4'd2;
  localparam logic [KEY_CODE_W-1:0] KEY_DIV = 4'd3;
  localparam logic [KEY_CODE_W-1:0] KEY_4   = 4'd4;
  localparam logic [KEY_CODE_W-1:0] KEY_5   = 4'd5;
  localparam logic [KEY_CODE_W-1:0] KEY_6   = 4'd6;
  localparam logic [KEY_CODE_W-1:0] KEY_MUL = 4'd7;
  localparam logic [KEY_CODE_W-1:0] KEY_1   = 4'd8;
  localparam logic [KEY_CODE_W-1:0] KEY_2   = 4'd9;
  localparam logic [KEY_CODE_W-1:0] KEY_3   = 4'd10;
  localparam logic [KEY_CODE_W-1:0] KEY_SUB = 4'd11;
  localparam logic [KEY_CODE_W-1:0] KEY_0   = 4'd12;
  localparam logic [KEY_CODE_W-1:0] KEY_DOT = 4'd13;
  localparam logic [KEY_CODE_W-1:0] KEY_EQ  = 4'd14;
  localparam logic [KEY_CODE_W-1:0] KEY_ADD = 4'd15;

  function automatic logic [KEY_CODE_W-1:0] key_code_of(input int row, input int col,
                                                        input int n_cols);
    return KEY_CODE_W'(row * n_cols + col);
  endfunction

endpackage

// File: rtl/keyb_scanner_if.sv
// Keypad-side bus of the scanner: row sense in, column strobes and key result out.
interface keyb_scanner_if
  import keyb_scanner_pkg::*;
#(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4
);

  logic [N_ROWS-1:0]     row_in;
  logic [N_COLS-1:0]     col_out;
  logic                  btn_press;
  logic [KEY_CODE_W-1:0] key_code;

  modport master (input row_in, output col_out, output btn_press, output key_code);
  modport slave  (output row_in, input col_out, input btn_press, input key_code);

endinterface

// File: rtl/keyb_row_sync.sv
// Two-flop synchronizer for the asynchronous row lines; idles at all ones
// so a reset never looks like a pressed key.
module keyb_row_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keyb_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, samples the
// synchronized rows once per settle period and holds the first key found.
module keyb_scanner
  import keyb_scanner_pkg::*;
#(
  parameter int N_COLS        = keyb_scanner_pkg::N_COLS,
  parameter int N_ROWS        = keyb_scanner_pkg::N_ROWS,
  parameter int SETTLE_CYCLES = 1000,
  parameter int CNT_W         = 10
) (
  input  logic           clk,
  input  logic           reset,
  keyb_scanner_if.master kb
);

  localparam int CIDX_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int RIDX_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CIDX_W-1:0] COL_LAST = CIDX_W'(N_COLS - 1);
  localparam logic [N_COLS-1:0] COL_ONE  = N_COLS'(1);

  state_e                state_q, state_d;
  logic [CIDX_W-1:0]     col_idx_q, col_idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_COLS-1:0]     col_out_q, col_out_d;
  logic                  btn_q, btn_d;
  logic [KEY_CODE_W-1:0] key_q, key_d;

  logic [N_ROWS-1:0] row_s;
  logic              tick_s;
  logic              any_low_s;
  logic [RIDX_W-1:0] low_row_s;
  logic [CIDX_W-1:0] col_nxt_s;

  keyb_row_sync #(.WIDTH(N_ROWS)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (kb.row_in),
    .q     (row_s)
  );

  // Lowest-index low row wins when several keys share the driven column
  always_comb begin
    low_row_s = '0;
    for (int r = N_ROWS - 1; r >= 0; r--) begin
      low_row_s = row_s[r] ? low_row_s : RIDX_W'(r);
    end
    any_low_s = ~&row_s;
    tick_s    = (cnt_q == CNT_MAX);
    col_nxt_s = (col_idx_q == COL_LAST) ? '0 : col_idx_q + CIDX_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    btn_d     = btn_q;
    key_d     = key_q;
    case (state_q)
      ST_SCAN: begin
        if (tick_s && any_low_s) begin
          state_d = ST_HOLD;
          btn_d   = 1'b1;
          key_d   = key_code_of(int'(low_row_s), int'(col_idx_q), N_COLS);
        end else if (tick_s) begin
          col_idx_d = col_nxt_s;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_HOLD: begin
        // Only a full release ends the hold; a row change keeps the latched code
        if (tick_s && !any_low_s) begin
          state_d   = ST_SCAN;
          btn_d     = 1'b0;
          col_idx_d = col_nxt_s;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d   = ST_SCAN;
        col_idx_d = '0;
        btn_d     = 1'b0;
        key_d     = '0;
      end
    endcase
    cnt_d = (tick_s || (state_d != state_q) || (col_idx_d != col_idx_q))
            ? '0 : cnt_q + CNT_W'(1);
    col_out_d = ~(COL_ONE << col_idx_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      col_idx_q <= '0;
      cnt_q     <= '0;
      col_out_q <= ~COL_ONE;
      btn_q     <= 1'b0;
      key_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      cnt_q     <= cnt_d;
      col_out_q <= col_out_d;
      btn_q     <= btn_d;
      key_q     <= key_d;
    end
  end

  assign kb.col_out   = col_out_q;
  assign kb.btn_press = btn_q;
  assign kb.key_code  = key_q;

endmodule

// File: tb/tb_keyb_scanner.sv
// Directed bench for keyb_scanner with SETTLE_CYCLES=4; a keypad model turns
// the set of held keys plus the driven column into row levels.
module tb_keyb_scanner;

  logic clk;
  logic reset;
  logic [15:0] keys_down;
  int checks;
  int errors;

  keyb_scanner_if #(.N_ROWS(4), .N_COLS(4)) kb ();

  keyb_scanner #(
    .N_COLS(4), .N_ROWS(4), .SETTLE_CYCLES(4), .CNT_W(2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .kb    (kb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] key_rows(input logic [15:0] down, input logic [3:0] cols);
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (down[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
    return rows;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      kb.row_in = key_rows(keys_down, kb.col_out);
    end
  endtask

  task automatic wait_btn(input logic exp, input int budget, input string tag);
    int n;
    n = 0;
    while (kb.btn_press !== exp && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, {31'd0, kb.btn_press}, {31'd0, exp});
  endtask

  logic [3:0] col_seq [4];

  initial begin
    checks    = 0;
    errors    = 0;
    keys_down = 16'h0000;
    kb.row_in = 4'hF;
    reset     = 1'b1;
    col_seq[0] = 4'b1101;
    col_seq[1] = 4'b1011;
    col_seq[2] = 4'b0111;
    col_seq[3] = 4'b1110;

    step(2);
    chk("rst_col", {28'd0, kb.col_out}, 32'h0000_000E);
    chk("rst_btn", {31'd0, kb.btn_press}, 32'd0);
    chk("rst_key", {28'd0, kb.key_code}, 32'd0);
    reset = 1'b0;

    // 1: idle scan, one column every 4 clocks
    for (int i = 0; i < 4; i++) begin
      step(3);
      chk("idle_col_hold", {28'd0, kb.col_out}, {28'd0, (i == 0) ? 4'b1110 : col_seq[i-1]});
      chk("idle_btn", {31'd0, kb.btn_press}, 32'd0);
      step(1);
      chk("idle_col_next", {28'd0, kb.col_out}, {28'd0, col_seq[i]});
      chk("idle_key", {28'd0, kb.key_code}, 32'd0);
    end

    // 2: key 10 (row 2, col 2)
    keys_down = 16'h0400;
    kb.row_in = key_rows(keys_down, kb.col_out);
    wait_btn(1'b1, 18, "press10_btn");
    chk("press10_key", {28'd0, kb.key_code}, 32'd10);
    chk("press10_col", {28'd0, kb.col_out}, 32'h0000_000B);
    step(8);
    chk("hold10_col", {28'd0, kb.col_out}, 32'h0000_000B);
    chk("hold10_btn", {31'd0, kb.btn_press}, 32'd1);

    // 3: release key 10
    keys_down = 16'h0000;
    kb.row_in = key_rows(keys_down, kb.col_out);
    wait_btn(1'b0, 6, "rel10_btn");
    chk("rel10_key", {28'd0, kb.key_code}, 32'd10);
    chk("rel10_col", {28'd0, kb.col_out}, 32'h0000_0007);

    // 4: rows 1 and 3 in column 0, lower row wins
    keys_down = 16'h1010;
    kb.row_in = key_rows(keys_down, kb.col_out);
    wait_btn(1'b1, 18, "multi_btn");
    chk("multi_key", {28'd0, kb.key_code}, 32'd4);
    chk("multi_col", {28'd0, kb.col_out}, 32'h0000_000E);
    keys_down = 16'h0000;
    kb.row_in = key_rows(keys_down, kb.col_out);
    wait_btn(1'b0, 6, "multi_rel_btn");
    chk("multi_rel_key", {28'd0, kb.key_code}, 32'd4);
    chk("multi_rel_col", {28'd0, kb.col_out}, 32'h0000_000D);

    // 5: async reset while holding key 10
    keys_down = 16'h0400;
    kb.row_in = key_rows(keys_down, kb.col_out);
    wait_btn(1'b1, 18, "rst_hold_btn");
    chk("rst_hold_key", {28'd0, kb.key_code}, 32'd10);
    reset     = 1'b1;
    keys_down = 16'h0000;
    kb.row_in = 4'hF;
    #1;
    chk("async_btn", {31'd0, kb.btn_press}, 32'd0);
    chk("async_key", {28'd0, kb.key_code}, 32'd0);
    chk("async_col", {28'd0, kb.col_out}, 32'h0000_000E);
    step(1);
    reset = 1'b0;
    step(3);
    chk("restart_col0", {28'd0, kb.col_out}, 32'h0000_000E);
    step(1);
    chk("restart_col1", {28'd0, kb.col_out}, 32'h0000_000D);

    // 6: one-clock row glitch between ticks is never sampled
    reset = 1'b1;
    step(1);
    reset     = 1'b0;
    kb.row_in = 4'b1110;
    step(1);
    step(2);
    chk("glitch_btn_a", {31'd0, kb.btn_press}, 32'd0);
    chk("glitch_col_a", {28'd0, kb.col_out}, 32'h0000_000E);
    step(1);
    chk("glitch_col_b", {28'd0, kb.col_out}, 32'h0000_000D);
    chk("glitch_btn_b", {31'd0, kb.btn_press}, 32'd0);
    step(4);
    chk("glitch_col_c", {28'd0, kb.col_out}, 32'h0000_000B);
    chk("glitch_btn_c", {31'd0, kb.btn_press}, 32'd0);
    chk("glitch_key", {28'd0, kb.key_code}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
